// File: rtl/fetch_queue.sv
// fetch_queue
// -----------------------------------------------------------------------------
// Instruction queue between the dual-fetch IF stage and the dual decoder.
// Each accepted fetch pair becomes two sequential single-instruction entries
// {pc, instr}. The two oldest entries are presented to decode, which consumes
// 0, 1 or 2 of them per cycle. Decode back-pressure therefore does not stall
// fetch until the buffer is nearly full.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-low reset
//   fetch_valid   fetch pair valid this cycle
//   fetch_pc      PC of fetch_instr0 (fetch_instr1 sits at fetch_pc+4)
//   fetch_instr0  first fetched instruction
//   fetch_instr1  second fetched instruction
//   fetch_stall   queue cannot take a pair; drives the IF stage stall
//   flush         discard all buffered entries (taken branch / redirect)
//   deq_count     entries decode consumes this cycle (3 behaves as 2)
//   out_valid0/out_pc0/out_instr0  head entry
//   out_valid1/out_pc1/out_instr1  entry after the head
// -----------------------------------------------------------------------------
module fetch_queue #(
  parameter int DEPTH = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_valid,
  input  logic [31:0] fetch_pc,
  input  logic [31:0] fetch_instr0,
  input  logic [31:0] fetch_instr1,
  output logic        fetch_stall,
  input  logic        flush,
  input  logic [1:0]  deq_count,
  output logic        out_valid0,
  output logic [31:0] out_pc0,
  output logic [31:0] out_instr0,
  output logic        out_valid1,
  output logic [31:0] out_pc1,
  output logic [31:0] out_instr1
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [AW:0]   count_q, count_d;

  logic [AW-1:0] head_p1;
  logic [AW-1:0] tail_p1;
  logic [AW:0]   deq_req;
  logic [AW:0]   deq_amt;
  logic          enq;

  // Entry storage; not reset and not cleared by flush, validity lives in count.
  logic [31:0] pc_mem    [DEPTH];
  logic [31:0] instr_mem [DEPTH];

  assign head_p1 = head_q + 1'b1;
  assign tail_p1 = tail_q + 1'b1;

  // Stall looks only at the registered count, so there is no combinational
  // path from decode's deq_count back into the IF stage.
  assign fetch_stall = (count_q > (AW+1)'(DEPTH - 2));

  assign enq = fetch_valid & ~fetch_stall & ~flush;

  always_comb begin
    // deq_count of 3 is treated as 2, then clamped to what is actually held.
    deq_req = (deq_count == 2'd3) ? (AW+1)'(2) : (AW+1)'(deq_count);
    deq_amt = (count_q < deq_req) ? count_q : deq_req;
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + deq_amt[AW-1:0];
      tail_d  = enq ? (tail_q + AW'(2)) : tail_q;
      count_d = count_q + (enq ? (AW+1)'(2) : '0) - deq_amt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Both halves of a pair are written in the same cycle; tail_p1 wraps to 0
  // when the pair straddles the end of the buffer.
  always_ff @(posedge clk) begin
    if (enq) begin
      pc_mem[tail_q]     <= fetch_pc;
      instr_mem[tail_q]  <= fetch_instr0;
      pc_mem[tail_p1]    <= fetch_pc + 32'd4;
      instr_mem[tail_p1] <= fetch_instr1;
    end
  end

  assign out_valid0 = (count_q >= (AW+1)'(1));
  assign out_valid1 = (count_q >= (AW+1)'(2));
  assign out_pc0    = pc_mem[head_q];
  assign out_instr0 = instr_mem[head_q];
  assign out_pc1    = pc_mem[head_p1];
  assign out_instr1 = instr_mem[head_p1];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH = 8).
module tb_fetch_queue;

  logic        clk;
  logic        reset;
  logic        fetch_valid;
  logic [31:0] fetch_pc;
  logic [31:0] fetch_instr0;
  logic [31:0] fetch_instr1;
  logic        fetch_stall;
  logic        flush;
  logic [1:0]  deq_count;
  logic        out_valid0;
  logic [31:0] out_pc0;
  logic [31:0] out_instr0;
  logic        out_valid1;
  logic [31:0] out_pc1;
  logic [31:0] out_instr1;

  int tests;
  int failed;

  localparam logic [31:0] IKEY = 32'hF0F0_0000;

  fetch_queue #(.DEPTH(8)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_valid  (fetch_valid),
    .fetch_pc     (fetch_pc),
    .fetch_instr0 (fetch_instr0),
    .fetch_instr1 (fetch_instr1),
    .fetch_stall  (fetch_stall),
    .flush        (flush),
    .deq_count    (deq_count),
    .out_valid0   (out_valid0),
    .out_pc0      (out_pc0),
    .out_instr0   (out_instr0),
    .out_valid1   (out_valid1),
    .out_pc1      (out_pc1),
    .out_instr1   (out_instr1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Instruction word stored for a given PC: the first pair uses 0xA/0xB,
  // every other pair is tagged with its PC.
  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    if (pc == 32'h100) return 32'hA;
    if (pc == 32'h104) return 32'hB;
    return pc ^ IKEY;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic fl, input logic [1:0] dq);
    fetch_valid  = v;
    fetch_pc     = pc;
    fetch_instr0 = instr_of(pc);
    fetch_instr1 = instr_of(pc + 32'd4);
    flush        = fl;
    deq_count    = dq;
  endtask

  // Advance one edge, then settle away from it before sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int          cnt;
  logic [31:0] head_pc;
  logic [31:0] nxt_pc;
  int          d;

  initial begin
    tests  = 0;
    failed = 0;
    reset  = 1'b0;
    drive(1'b0, 32'h0, 1'b0, 2'd0);
    tick();
    tick();
    chk("reset_valid0", out_valid0, 1'b0);
    chk("reset_valid1", out_valid1, 1'b0);
    chk("reset_stall", fetch_stall, 1'b0);
    reset = 1'b1;

    // First pair, one-cycle latency to the outputs.
    drive(1'b1, 32'h100, 1'b0, 2'd0);
    tick();
    chk("first_valid0", out_valid0, 1'b1);
    chk("first_valid1", out_valid1, 1'b1);
    chk("first_pc0", out_pc0, 32'h100);
    chk("first_pc1", out_pc1, 32'h104);
    chk("first_instr0", out_instr0, 32'hA);
    chk("first_instr1", out_instr1, 32'hB);

    // Pairs 2 and 3: count 6, not yet stalling.
    drive(1'b1, 32'h108, 1'b0, 2'd0);
    tick();
    drive(1'b1, 32'h110, 1'b0, 2'd0);
    tick();
    chk("cnt6_stall", fetch_stall, 1'b0);
    // Pair 4: count 8, stall.
    drive(1'b1, 32'h118, 1'b0, 2'd0);
    tick();
    chk("cnt8_stall", fetch_stall, 1'b1);
    // Pair 5 presented while stalled must be dropped.
    drive(1'b1, 32'h120, 1'b0, 2'd0);
    tick();
    chk("stalled_stall", fetch_stall, 1'b1);
    chk("stalled_head", out_pc0, 32'h100);

    // Drain one per cycle while fetch keeps presenting; head and tail wrap.
    cnt     = 8;
    head_pc = 32'h100;
    nxt_pc  = 32'h120;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, nxt_pc, 1'b0, 2'd1);
      d = (cnt > 0) ? 1 : 0;
      if (cnt <= 6) begin
        cnt    = cnt + 2;
        nxt_pc = nxt_pc + 32'd8;
      end
      cnt     = cnt - d;
      head_pc = head_pc + 32'(4 * d);
      tick();
      chk($sformatf("wrap%0d_pc0", i), out_pc0, head_pc);
      chk($sformatf("wrap%0d_pc1", i), out_pc1, head_pc + 32'd4);
      chk($sformatf("wrap%0d_instr0", i), out_instr0, instr_of(head_pc));
      chk($sformatf("wrap%0d_instr1", i), out_instr1, instr_of(head_pc + 32'd4));
      chk($sformatf("wrap%0d_stall", i), fetch_stall, (cnt > 6) ? 1'b1 : 1'b0);
    end

    // Empty the queue, then build count=1.
    drive(1'b0, 32'h0, 1'b1, 2'd0);
    tick();
    chk("flush_empty_valid0", out_valid0, 1'b0);
    drive(1'b1, 32'h200, 1'b0, 2'd0);
    tick();
    drive(1'b0, 32'h0, 1'b0, 2'd1);
    tick();
    chk("cnt1_valid0", out_valid0, 1'b1);
    chk("cnt1_valid1", out_valid1, 1'b0);
    chk("cnt1_pc0", out_pc0, 32'h204);
    // Over-request: clamp to 0, no underflow.
    drive(1'b0, 32'h0, 1'b0, 2'd2);
    tick();
    chk("clamp_valid0", out_valid0, 1'b0);
    chk("clamp_valid1", out_valid1, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 2'd3);
    tick();
    chk("clamp_empty_stall", fetch_stall, 1'b0);
    chk("clamp_empty_valid0", out_valid0, 1'b0);
    drive(1'b1, 32'h300, 1'b0, 2'd0);
    tick();
    chk("after_clamp_pc0", out_pc0, 32'h300);
    chk("after_clamp_valid1", out_valid1, 1'b1);
    chk("after_clamp_stall", fetch_stall, 1'b0);

    // Build count=5, then flush together with enqueue and dequeue.
    drive(1'b1, 32'h308, 1'b0, 2'd1);
    tick();
    drive(1'b1, 32'h310, 1'b0, 2'd0);
    tick();
    chk("cnt5_pc0", out_pc0, 32'h304);
    chk("cnt5_stall", fetch_stall, 1'b0);
    drive(1'b1, 32'h400, 1'b1, 2'd2);
    tick();
    chk("flush_valid0", out_valid0, 1'b0);
    chk("flush_valid1", out_valid1, 1'b0);
    chk("flush_stall", fetch_stall, 1'b0);
    drive(1'b0, 32'h0, 1'b0, 2'd0);
    tick();
    chk("flush_dropped", out_valid0, 1'b0);
    drive(1'b1, 32'h500, 1'b0, 2'd0);
    tick();
    chk("post_flush_pc0", out_pc0, 32'h500);
    chk("post_flush_pc1", out_pc1, 32'h504);

    // count=4, then asynchronous reset between edges.
    drive(1'b1, 32'h600, 1'b0, 2'd0);
    tick();
    chk("pre_reset_valid1", out_valid1, 1'b1);
    drive(1'b0, 32'h0, 1'b0, 2'd0);
    #2;
    reset = 1'b0;
    #1;
    chk("async_valid0", out_valid0, 1'b0);
    chk("async_valid1", out_valid1, 1'b0);
    chk("async_stall", fetch_stall, 1'b0);
    tick();
    reset = 1'b1;

    // Restart after reset; PC+4 wraps at 2^32.
    drive(1'b1, 32'hFFFF_FFFC, 1'b0, 2'd0);
    tick();
    chk("restart_valid0", out_valid0, 1'b1);
    chk("restart_pc0", out_pc0, 32'hFFFF_FFFC);
    chk("pc_wrap_pc1", out_pc1, 32'h0000_0000);
    chk("pc_wrap_instr1", out_instr1, 32'h0 ^ IKEY);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
